alu_exec: RTL

Multi-cycle execute stage between the register file's registered read ports and its write port. Captures `dataA`/`dataB` on a start strobe and evaluates a 4-bit opcode. Single-cycle logic and add ops finish in one cycle; shifts run iteratively, one bit per cycle; multiply uses shift-add over 16 cycles. Results return to the register file as `dataW`/`regW`/`RFwrite`, with N/Z/C flags.

---
 rtl/alu_exec.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/alu_exec.sv
// alu_exec: multi-cycle execute stage between register-file read and write ports.
// Ports: CLK, reset (sync, active-high), start/op/rd/dataA/dataB in;
//        busy, done, err, RFwrite, regW, dataW, flagN/Z/C out.
// Optional multiplier built when ALU_MUL_EN is defined; otherwise op 7 is illegal.
module alu_exec #(
    parameter int WIDTH   = 16,
    parameter int REGBITS = 3
) (
    input  logic               CLK,
    input  logic               reset,
    input  logic               start,
    input  logic [3:0]         op,
    input  logic [REGBITS-1:0] rd,
    input  logic [WIDTH-1:0]   dataA,
    input  logic [WIDTH-1:0]   dataB,
    output logic               busy,
    output logic               done,
    output logic               err,
    output logic               RFwrite,
    output logic [REGBITS-1:0] regW,
    output logic [WIDTH-1:0]   dataW,
    output logic               flagN,
    output logic               flagZ,
    output logic               flagC
);

    typedef enum logic [3:0] {
        OP_ADD = 4'd0,
        OP_SUB = 4'd1,
        OP_AND = 4'd2,
        OP_OR  = 4'd3,
        OP_NOT = 4'd4,
        OP_SHL = 4'd5,
        OP_SHR = 4'd6,
        OP_MUL = 4'd7,
        OP_MOV = 4'd8
    } op_e;

    typedef enum logic [2:0] {
        S_IDLE, S_EXEC, S_SHIFT, S_MUL, S_WB
    } state_e;

    state_e               state_q;
    logic [3:0]           op_q;
    logic [REGBITS-1:0]   rd_q;
    logic [WIDTH-1:0]     a_q;
    logic [WIDTH-1:0]     b_q;
    logic [4:0]           cnt_q;
    logic                 sc_q;
    logic                 done_q;
    logic                 err_q;
    logic                 wr_q;
    logic [REGBITS-1:0]   regW_q;
    logic [WIDTH-1:0]     dataW_q;
    logic                 n_q;
    logic                 z_q;
    logic                 c_q;
`ifdef ALU_MUL_EN
    logic [2*WIDTH-1:0]   acc_q;
    logic [2*WIDTH-1:0]   mc_q;
`endif

    logic                 legal_d;
    logic                 shift_d;
    logic                 fin_d;
    logic [WIDTH-1:0]     res_d;
    logic                 cy_d;
    logic [WIDTH:0]       sum_d;

`ifdef ALU_MUL_EN
    assign legal_d = (op <= 4'd8);
`else
    assign legal_d = (op <= 4'd8) && (op != OP_MUL);
`endif
    assign shift_d = (op == OP_SHL) || (op == OP_SHR);

    // Result/carry of whichever state finishes this cycle.
    always_comb begin
        sum_d = {1'b0, a_q} + {1'b0, b_q};
        res_d = '0;
        cy_d  = 1'b0;
        fin_d = 1'b0;
        case (op_q)
            OP_ADD: begin
                res_d = sum_d[WIDTH-1:0];
                cy_d  = sum_d[WIDTH];
            end
            OP_SUB: begin
                res_d = a_q - b_q;
                cy_d  = (a_q < b_q);
            end
            OP_AND: res_d = a_q & b_q;
            OP_OR:  res_d = a_q | b_q;
            OP_NOT: res_d = ~a_q;
            OP_MOV: res_d = b_q;
            default: ;
        endcase
        case (state_q)
            S_EXEC: fin_d = 1'b1;
            S_SHIFT: begin
                fin_d = (cnt_q == 5'd0);
                res_d = a_q;
                cy_d  = sc_q;
            end
`ifdef ALU_MUL_EN
            S_MUL: begin
                fin_d = (cnt_q == 5'd16);
                res_d = acc_q[WIDTH-1:0];
                cy_d  = |acc_q[2*WIDTH-1:WIDTH];
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            state_q <= S_IDLE;
            op_q    <= '0;
            rd_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            cnt_q   <= '0;
            sc_q    <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            wr_q    <= 1'b0;
            regW_q  <= '0;
            dataW_q <= '0;
            n_q     <= 1'b0;
            z_q     <= 1'b0;
            c_q     <= 1'b0;
`ifdef ALU_MUL_EN
            acc_q   <= '0;
            mc_q    <= '0;
`endif
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            wr_q   <= 1'b0;
            case (state_q)
                S_IDLE: if (start) begin
                    op_q  <= op;
                    rd_q  <= rd;
                    a_q   <= dataA;
                    b_q   <= dataB;
                    cnt_q <= {1'b0, dataB[3:0]};
                    sc_q  <= 1'b0;
                    if (!legal_d) begin
                        // Illegal op: straight to WB, flags/data untouched.
                        state_q <= S_WB;
                        done_q  <= 1'b1;
                        err_q   <= 1'b1;
                    end else if (shift_d) begin
                        state_q <= S_SHIFT;
`ifdef ALU_MUL_EN
                    end else if (op == OP_MUL) begin
                        state_q <= S_MUL;
                        cnt_q   <= '0;
                        acc_q   <= '0;
                        mc_q    <= {{WIDTH{1'b0}}, dataA};
`endif
                    end else begin
                        state_q <= S_EXEC;
                    end
                end
                S_SHIFT: if (cnt_q != 5'd0) begin
                    if (op_q == OP_SHL) begin
                        sc_q <= a_q[WIDTH-1];
                        a_q  <= a_q << 1;
                    end else begin
                        sc_q <= a_q[0];
                        a_q  <= a_q >> 1;
                    end
                    cnt_q <= cnt_q - 5'd1;
                end
`ifdef ALU_MUL_EN
                S_MUL: if (cnt_q != 5'd16) begin
                    if (b_q[0]) acc_q <= acc_q + mc_q;
                    mc_q  <= mc_q << 1;
                    b_q   <= b_q >> 1;
                    cnt_q <= cnt_q + 5'd1;
                end
`endif
                S_WB: state_q <= S_IDLE;
                default: ;
            endcase
            if (fin_d) begin
                state_q <= S_WB;
                done_q  <= 1'b1;
                wr_q    <= 1'b1;
                regW_q  <= rd_q;
                dataW_q <= res_d;
                n_q     <= res_d[WIDTH-1];
                z_q     <= (res_d == '0);
                c_q     <= cy_d;
            end
        end
    end

    assign busy    = (state_q != S_IDLE);
    assign done    = done_q;
    assign err     = err_q;
    assign RFwrite = wr_q;
    assign regW    = regW_q;
    assign dataW   = dataW_q;
    assign flagN   = n_q;
    assign flagZ   = z_q;
    assign flagC   = c_q;

endmodule
